// File: rtl/status_logger_if.sv
// status_logger_if: status stream input and replay read port of the status logger
interface status_logger_if #(
  parameter int AW = 10
);
  logic [1:0]    i_status;
  logic          i_status_valid;
  logic          i_rd_start;
  logic          i_rd_ready;
  logic [1:0]    o_rd_data;
  logic [AW-1:0] o_rd_idx;
  logic          o_rd_valid;
  logic          o_rd_last;
  modport master (
    output i_status, i_status_valid, i_rd_start, i_rd_ready,
    input  o_rd_data, o_rd_idx, o_rd_valid, o_rd_last
  );
  modport slave (
    input  i_status, i_status_valid, i_rd_start, i_rd_ready,
    output o_rd_data, o_rd_idx, o_rd_valid, o_rd_last
  );
endinterface

// File: rtl/status_logger.sv
// status_logger: logs the core status stream, freezes on a terminal status and replays the log over valid/ready
module status_logger #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int CW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  status_logger_if.slave sl,
  output logic [AW:0]   o_count,
  output logic          o_halted,
  output logic          o_full,
  output logic [1:0]    o_term_code,
  output logic [CW-1:0] o_cnt_r,
  output logic [CW-1:0] o_cnt_i,
  output logic [CW-1:0] o_drop_cnt
);
  typedef enum logic [2:0] {CAPTURE, HALT, FULL, DRAIN, DONE} state_t;
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  state_t        state_q, state_d;
  logic [1:0]    log_mem [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic          halted_q, halted_d, full_q, full_d;
  logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [1:0]    term_q, term_d, rd_data_q, rd_data_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d, nxt_idx;
  logic [CW-1:0] cnt_r_q, cnt_r_d, cnt_i_q, cnt_i_d, drop_q, drop_d;
  logic          capture, term, start, accept, advance;
  always_comb begin
    capture    = state_q == CAPTURE && sl.i_status_valid;
    term       = capture && sl.i_status[1];
    start      = (state_q == HALT || state_q == FULL) && sl.i_rd_start && count_q != '0;
    accept     = state_q == DRAIN && rd_valid_q && sl.i_rd_ready;
    advance    = accept && !rd_last_q;
    nxt_idx    = rd_idx_q + AW'(1);
    count_d    = count_q + (AW+1)'(capture);
    cnt_r_d    = cnt_r_q + CW'(capture && sl.i_status == 2'd0 && ~&cnt_r_q);
    cnt_i_d    = cnt_i_q + CW'(capture && sl.i_status == 2'd1 && ~&cnt_i_q);
    drop_d     = drop_q + CW'(state_q != CAPTURE && sl.i_status_valid && ~&drop_q);
    halted_d   = halted_q || term;
    full_d     = full_q || (capture && !term && count_q == LAST);
    term_d     = term ? sl.i_status : term_q;
    rd_valid_d = start || (rd_valid_q && !(accept && rd_last_q));
    rd_idx_d   = start ? '0 : advance ? nxt_idx : rd_idx_q;
    rd_data_d  = start ? log_mem[0] : advance ? log_mem[nxt_idx] : rd_data_q;
    rd_last_d  = start ? count_q == (AW+1)'(1) :
                 advance ? {1'b0, nxt_idx} == count_q - (AW+1)'(1) : rd_last_q;
    state_d    = term ? HALT :
                 capture && count_q == LAST ? FULL :
                 start ? DRAIN :
                 accept && rd_last_q ? DONE : state_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state_q    <= CAPTURE;
      count_q    <= '0;
      halted_q   <= 1'b0;
      full_q     <= 1'b0;
      term_q     <= '0;
      cnt_r_q    <= '0;
      cnt_i_q    <= '0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
      full_q     <= full_d;
      term_q     <= term_d;
      cnt_r_q    <= cnt_r_d;
      cnt_i_q    <= cnt_i_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (capture) log_mem[count_q[AW-1:0]] <= sl.i_status;
  end
  assign o_count     = count_q;
  assign o_halted    = halted_q;
  assign o_full      = full_q;
  assign o_term_code = term_q;
  assign o_cnt_r     = cnt_r_q;
  assign o_cnt_i     = cnt_i_q;
  assign o_drop_cnt  = drop_q;
  assign sl.o_rd_data  = rd_data_q;
  assign sl.o_rd_idx   = rd_idx_q;
  assign sl.o_rd_valid = rd_valid_q;
  assign sl.o_rd_last  = rd_last_q;
endmodule

// File: tb/tb_status_logger.sv
// tb_status_logger: randomized and directed checks of status_logger against a queue-based log model
module tb_status_logger;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic [AW:0] count;
  logic halted, full;
  logic [1:0] term_code;
  logic [CW-1:0] cnt_r, cnt_i, drop_cnt;
  int n_checks = 0;
  int n_pass = 0;
  int mq[$];
  bit m_halted, m_full, m_drained;
  int m_term, m_r, m_i, m_drop;
  status_logger_if #(.AW(AW)) bus ();
  status_logger #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .sl(bus),
    .o_count(count), .o_halted(halted), .o_full(full), .o_term_code(term_code),
    .o_cnt_r(cnt_r), .o_cnt_i(cnt_i), .o_drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic void mclear();
    mq.delete();
    m_halted = 0; m_full = 0; m_drained = 0;
    m_term = 0; m_r = 0; m_i = 0; m_drop = 0;
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mclear();
  endtask
  task automatic cycle(input bit v, input logic [1:0] s, input bit clr);
    bus.i_status = s;
    bus.i_status_valid = v;
    clear = clr;
    @(negedge clk);
    bus.i_status_valid = 1'b0;
    clear = 1'b0;
    if (clr) mclear();
    else if (v) begin
      if (!m_halted && !m_full) begin
        mq.push_back(int'(s));
        if (s == 2'd0) m_r++;
        if (s == 2'd1) m_i++;
        if (s >= 2'd2) begin
          m_halted = 1;
          m_term = int'(s);
        end else if (mq.size() == DEPTH) m_full = 1;
      end else if (m_drop < 65535) m_drop++;
    end
  endtask
  task automatic push(input logic [1:0] s);
    cycle(1'b1, s, 1'b0);
  endtask
  task automatic check_all(input string t);
    check({t, "_count"}, 32'(count), mq.size());
    check({t, "_halted"}, 32'(halted), 32'(m_halted));
    check({t, "_full"}, 32'(full), 32'(m_full));
    check({t, "_term"}, 32'(term_code), m_term);
    check({t, "_cnt_r"}, 32'(cnt_r), m_r);
    check({t, "_cnt_i"}, 32'(cnt_i), m_i);
    check({t, "_drop"}, 32'(drop_cnt), m_drop);
  endtask
  task automatic drain(input string t, input int mode);
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int n = mq.size();
    int k = 0;
    bit go = (m_halted || m_full) && !m_drained && n > 0;
    bit rdy;
    bus.i_rd_start = 1'b1;
    @(negedge clk);
    bus.i_rd_start = 1'b0;
    if (!go) begin
      check({t, "_ignored_valid"}, 32'(bus.o_rd_valid), 0);
      return;
    end
    m_drained = 1;
    for (int c = 0; c < 300 && k < n; c++) begin
      check({t, "_rd_valid"}, 32'(bus.o_rd_valid), 1);
      check({t, "_rd_data"}, 32'(bus.o_rd_data), mq[k]);
      check({t, "_rd_idx"}, 32'(bus.o_rd_idx), k);
      check({t, "_rd_last"}, 32'(bus.o_rd_last), 32'(k == n - 1));
      rdy = mode == 0 ? 1'b1 : mode == 2 ? (c < 7 ? pat[c] != 0 : 1'b1) :
            c >= 100 ? 1'b1 : 1'($urandom_range(0, 1));
      bus.i_rd_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
    end
    bus.i_rd_ready = 1'b0;
    check({t, "_delivered"}, k, n);
    check({t, "_valid_off"}, 32'(bus.o_rd_valid), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_status = '0;
    bus.i_status_valid = 1'b0;
    bus.i_rd_start = 1'b0;
    bus.i_rd_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check_all("rst");
    check("rst_rd_valid", 32'(bus.o_rd_valid), 0);
    check("rst_rd_last", 32'(bus.o_rd_last), 0);
    check("rst_rd_idx", 32'(bus.o_rd_idx), 0);
    check("rst_rd_data", 32'(bus.o_rd_data), 0);
    push(2'd0); push(2'd1); push(2'd0); push(2'd3);
    check("t1_count", 32'(count), 4);
    check("t1_cnt_r", 32'(cnt_r), 2);
    check("t1_cnt_i", 32'(cnt_i), 1);
    check("t1_halted", 32'(halted), 1);
    check("t1_term", 32'(term_code), 3);
    drain("t1", 0);
    drain("t1_done", 0);
    check_all("t1_end");
    do_reset();
    push(2'd1); push(2'd0); push(2'd1); push(2'd0); push(2'd1); push(2'd2);
    push(2'd0); push(2'd1); push(2'd3);
    check("t2_count", 32'(count), 6);
    check("t2_term", 32'(term_code), 2);
    check("t2_drop", 32'(drop_cnt), 3);
    check_all("t2");
    do_reset();
    for (int i = 0; i < 8; i++) push(2'd1);
    check("t3_full", 32'(full), 1);
    check("t3_halted", 32'(halted), 0);
    check("t3_cnt_i", 32'(cnt_i), 8);
    push(2'd0);
    check("t3_drop", 32'(drop_cnt), 1);
    drain("t3", 1);
    check_all("t3");
    do_reset();
    for (int i = 0; i < 7; i++) push(2'd0);
    push(2'd3);
    check("t3b_halted", 32'(halted), 1);
    check("t3b_full", 32'(full), 0);
    check_all("t3b");
    do_reset();
    push(2'd1); push(2'd0); push(2'd1); push(2'd3);
    drain("t4", 2);
    check_all("t4");
    do_reset();
    push(2'd0);
    drain("t5_cap", 1);
    push(2'd1); push(2'd0); push(2'd3);
    bus.i_rd_start = 1'b1;
    @(negedge clk);
    bus.i_rd_start = 1'b0;
    bus.i_rd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_idx", 32'(bus.o_rd_idx), 2);
    check("t5_valid_mid", 32'(bus.o_rd_valid), 1);
    do_reset();
    bus.i_rd_ready = 1'b0;
    check("t5_valid_abort", 32'(bus.o_rd_valid), 0);
    check("t5_count", 32'(count), 0);
    push(2'd1);
    check("t5_capture", 32'(count), 1);
    do_reset();
    push(2'd0); push(2'd1);
    cycle(1'b1, 2'd3, 1'b1);
    check("t6_count", 32'(count), 0);
    check("t6_halted", 32'(halted), 0);
    check_all("t6");
    for (int it = 0; it < 40; it++) begin
      int n = $urandom_range(0, 11);
      do_reset();
      for (int j = 0; j < n; j++) begin
        int r = $urandom_range(0, 9);
        cycle($urandom_range(0, 3) != 0, r < 4 ? 2'd0 : r < 8 ? 2'd1 : r == 8 ? 2'd2 : 2'd3,
              $urandom_range(0, 24) == 0);
      end
      check_all("rnd_cap");
      drain("rnd", 1);
      cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      drain("rnd_again", 1);
      check_all("rnd_end");
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
